phased_array_axil_regbank: RTL
==============================

Name: phased_array_axil_regbank

Overview:
- Parametrised AXI4-Lite slave register bank for the ultrasonic phased-array transmitter. It replaces the fixed four-register slave.
- Holds NUM_CH per-channel delay registers in a double-buffered arrangement. Software writes shadow registers; the whole array moves to the active outputs atomically on the next frame_sync after a commit request.
- Sits between the PS AXI interconnect and the per-channel pulse generators.

Parameters:
- NUM_CH, 16, number of transducer channels (1..64).
- DELAY_W, 16, width of each channel delay value in clocks (1..32).
- C_S_AXI_ADDR_WIDTH, 8, byte address width; must cover 0x10 + 4*NUM_CH.
- C_S_AXI_DATA_WIDTH, 32, AXI data width; fixed at 32.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake.
- S_AXI_BRESP  out  2  OKAY=2'b00, SLVERR=2'b10.
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake.
- frame_sync  in  1  one-cycle pulse marking the start of a transmit frame.
- tx_enable  out  1  CTRL.enable.
- period  out  32  frame period register.
- delay_active  out  NUM_CH*DELAY_W  active delays; channel i occupies bits [i*DELAY_W +: DELAY_W].

Behaviour:
- One clock, S_AXI_ACLK. Reset is synchronous and active-high on S_AXI_ARESET.
- Reset values:
  - All READY and VALID outputs 0; BRESP, RRESP and RDATA 0.
  - tx_enable 0; period 0; all shadow and active delays 0; commit_pending 0.
- Register map (word-aligned; byte address bits [1:0] ignored):
  - 0x00 CTRL: bit0 enable (RW); bit1 commit (W1S; reads back commit_pending).
  - 0x04 STATUS (RO): bit0 commit_pending; bits[15:8] NUM_CH; bits[23:16] DELAY_W.
  - 0x08 PERIOD (RW, 32 bits).
  - 0x0C ID (RO): 32'h50410002.
  - 0x10 + 4*i, for i = 0..NUM_CH-1: DELAY shadow i (RW, low DELAY_W bits). Upper bits read as 0.
- Write channel:
  - AWREADY and WREADY assert together for exactly one cycle when AWVALID && WVALID && !BVALID.
  - The register update happens on that same edge, per WSTRB byte.
  - BVALID asserts the next cycle and holds until BREADY.
  - At most one write is outstanding.
- Read channel:
  - ARREADY asserts for one cycle when ARVALID && !RVALID.
  - RVALID asserts the next cycle with RDATA registered, and holds with RDATA stable until RREADY.
- Invalid address (0x10 + 4*NUM_CH and above): response SLVERR, writes have no effect, reads return 0.
  - Writes to STATUS or ID return OKAY and have no effect.
- Commit:
  - A CTRL write with WSTRB[0]=1 and WDATA[1]=1 sets commit_pending.
  - On a cycle where frame_sync && tx_enable && commit_pending: all active delays load from shadow, and commit_pending clears.
  - delay_active is valid 1 cycle after that frame_sync edge.
  - frame_sync with tx_enable=0 is ignored; pending persists.
- Simultaneous events:
  - Commit write on the same edge as an applying frame_sync: that transfer uses the pre-edge shadow, and commit_pending remains 1 (set wins).
  - Shadow write on the same edge as a transfer: active gets the old value; the new value waits for the next commit.
  - Reset asserted mid-transaction: all handshake state is dropped, and no response is issued for the aborted transfer.

Optional Feature:
- Macro PA_COMMIT_IRQ_EN.
- When defined:
  - Adds output commit_irq (1 bit, reset 0).
  - STATUS bit1 (done) sets on every applied commit and is W1C.
  - CTRL bit2 is irq_mask (RW, reset 0). commit_irq = done && irq_mask, registered.
  - If set and clear land on the same edge, set wins.
- When undefined: no port; STATUS bit1 and CTRL bit2 read 0.

Test Plan:
- Reset, then write 0x1..0x4 to 0x00, 0x08, 0x10, 0x14 and read back -> CTRL reads 0x1 (bit1 = pending after W1S of 0x2? no: 0x1 written, so 0x1), PERIOD 0x2, DELAY0 0x3, DELAY1 0x4; all responses OKAY.
- DELAY0 holds 0xFFFF; write 0x0000AB00 with WSTRB=4'b0010 -> reads 0xABFF (DELAY_W=16); upper bytes stay 0.
- Write and read 0x50 with NUM_CH=16 -> BRESP and RRESP = 2'b10, RDATA = 0, no register changes.
- Shadow DELAY3=0x0123, enable=1, commit, then frame_sync -> delay_active[63:48] = 0x0123 one cycle later; STATUS bit0 returns to 0.
- Commit write on the same edge as a frame_sync while pending -> transfer occurs; STATUS bit0 still reads 1 afterwards.
- Hold BREADY low 10 cycles -> BVALID stays high and no second AWREADY; assert S_AXI_ARESET mid-hold -> BVALID=0 next cycle.

Source files
------------

// File: rtl/phased_array_axil_regbank.sv
// phased_array_axil_regbank
//   AXI4-Lite slave register bank for the ultrasonic phased-array transmitter.
//   Software writes per-channel delays into shadow registers. A commit request
//   moves the whole shadow array to delay_active atomically on the next enabled
//   frame_sync, so the pulse generators never see a half-updated delay set.
//   Optional feature macro: PA_COMMIT_IRQ_EN adds a sticky commit-done flag
//   (STATUS bit1, W1C), an irq mask (CTRL bit2) and the registered commit_irq output.
module phased_array_axil_regbank #(
  parameter int NUM_CH             = 16,
  parameter int DELAY_W            = 16,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic                              frame_sync,
  output logic                              tx_enable,
  output logic [31:0]                       period,
  output logic [NUM_CH*DELAY_W-1:0]         delay_active
`ifdef PA_COMMIT_IRQ_EN
  ,
  output logic                              commit_irq
`endif
);

  localparam int DW          = C_S_AXI_DATA_WIDTH;
  localparam int WORDS       = 4 + NUM_CH;
  localparam int ADDR_CTRL   = 0;
  localparam int ADDR_STATUS = 1;
  localparam int ADDR_PERIOD = 2;
  localparam int ADDR_ID     = 3;
  localparam int ADDR_DELAY0 = 4;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] ID_VALUE    = 32'h50410002;

  // Byte-lane merge of new write data into an existing register value.
  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0]   old_val,
                                                input logic [DW-1:0]   new_val,
                                                input logic [DW/8-1:0] strb);
    logic [DW-1:0] r;
    r = old_val;
    for (int b = 0; b < DW/8; b++) begin
      if (strb[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

  // Same merge for a delay register; bits above DELAY_W are simply not stored.
  function automatic logic [DELAY_W-1:0] merge_delay(input logic [DELAY_W-1:0] old_val,
                                                     input logic [DW-1:0]      new_val,
                                                     input logic [DW/8-1:0]    strb);
    logic [DW-1:0] r;
    r = merge_bytes(DW'(old_val), new_val, strb);
    return r[DELAY_W-1:0];
  endfunction

  logic [DELAY_W-1:0]          shadow [NUM_CH];
  logic                        commit_pending;
  logic                        commit_done;
  logic                        irq_mask;

  logic [C_S_AXI_ADDR_WIDTH-3:0] wr_word;
  logic [C_S_AXI_ADDR_WIDTH-3:0] rd_word;
  int                          wr_idx;
  int                          rd_idx;
  logic                        wr_en;
  logic                        wr_ok;
  logic                        commit_set;
  logic                        commit_apply;
  logic [DW-1:0]               rd_data;
  logic                        rd_ok;

  // Protection bits and byte offsets within a word carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_word      = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_word      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_idx       = int'(wr_word);
  assign rd_idx       = int'(rd_word);
  // AWREADY is only ever high while no response is outstanding, so this is a full write handshake.
  assign wr_en        = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
  assign wr_ok        = wr_idx < WORDS;
  assign commit_set   = wr_en && (wr_idx == ADDR_CTRL) && S_AXI_WSTRB[0] && S_AXI_WDATA[1];
  assign commit_apply = frame_sync && tx_enable && commit_pending;

  // Write channel: single-cycle AW/W ready pulse, then hold the response until BREADY.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
    end else begin
      S_AXI_AWREADY <= !S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID;
      S_AXI_WREADY  <= !S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID;
      if (wr_en) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  // Control and period registers updated on the write handshake edge.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      tx_enable <= 1'b0;
      period    <= '0;
    end else if (wr_en) begin
      if ((wr_idx == ADDR_CTRL) && S_AXI_WSTRB[0]) tx_enable <= S_AXI_WDATA[0];
      if (wr_idx == ADDR_PERIOD) period <= merge_bytes(period, S_AXI_WDATA, S_AXI_WSTRB);
    end
  end

  // Shadow delay registers, written byte-wise by software.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_idx == ADDR_DELAY0 + i) shadow[i] <= merge_delay(shadow[i], S_AXI_WDATA, S_AXI_WSTRB);
      end
    end
  end

  // Active delays copy the pre-edge shadow array in one shot on an applying frame_sync.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      delay_active <= '0;
    end else if (commit_apply) begin
      for (int i = 0; i < NUM_CH; i++) delay_active[i*DELAY_W +: DELAY_W] <= shadow[i];
    end
  end

  // Commit request flag: a new request on the applying edge keeps it set for the next frame.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      commit_pending <= 1'b0;
    end else begin
      commit_pending <= commit_set || (commit_pending && !commit_apply);
    end
  end

`ifdef PA_COMMIT_IRQ_EN
  logic done_clear;
  assign done_clear = wr_en && (wr_idx == ADDR_STATUS) && S_AXI_WSTRB[0] && S_AXI_WDATA[1];

  // Sticky commit-done flag, irq mask and registered interrupt; a new commit beats a clear.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      commit_done <= 1'b0;
      irq_mask    <= 1'b0;
      commit_irq  <= 1'b0;
    end else begin
      if (wr_en && (wr_idx == ADDR_CTRL) && S_AXI_WSTRB[0]) irq_mask <= S_AXI_WDATA[2];
      commit_done <= commit_apply || (commit_done && !done_clear);
      commit_irq  <= commit_done && irq_mask;
    end
  end
`else
  assign commit_done = 1'b0;
  assign irq_mask    = 1'b0;
`endif

  // Read-data multiplexer for the register map; unmapped words read 0 with an error.
  always_comb begin
    rd_data = '0;
    rd_ok   = 1'b1;
    if (rd_idx == ADDR_CTRL) begin
      rd_data = DW'({irq_mask, commit_pending, tx_enable});
    end else if (rd_idx == ADDR_STATUS) begin
      rd_data = DW'({8'h00, 8'(DELAY_W), 8'(NUM_CH), 6'b0, commit_done, commit_pending});
    end else if (rd_idx == ADDR_PERIOD) begin
      rd_data = DW'(period);
    end else if (rd_idx == ADDR_ID) begin
      rd_data = DW'(ID_VALUE);
    end else if (rd_idx < WORDS) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rd_idx == ADDR_DELAY0 + i) rd_data = DW'(shadow[i]);
      end
    end else begin
      rd_ok = 1'b0;
    end
  end

  // Read channel: single-cycle AR ready pulse, registered data held until RREADY.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      S_AXI_ARREADY <= !S_AXI_ARREADY && S_AXI_ARVALID && !S_AXI_RVALID;
      if (S_AXI_ARREADY && S_AXI_ARVALID) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_data;
        S_AXI_RRESP  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

endmodule
